// File: rtl/id_stage_hz.sv
// id_stage_hz: instruction decode with register file, load-use hazard detection and ID/EXE register.
// Optional macro ID_BYPASS_EN: a same-cycle WB write is forwarded to the register-file read ports.
module id_stage_hz #(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 32,
    parameter int IMM_W   = 16,
    localparam int REG_AW = $clog2(REG_CNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] pc_in,
    output logic              id_stall,
    input  logic              ex_ready,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    output logic              ex_wb_en,
    output logic [1:0]        ex_mem_sig,
    output logic [1:0]        ex_br_type,
    output logic [3:0]        ex_cmd,
    output logic [DATA_W-1:0] ex_val1,
    output logic [DATA_W-1:0] ex_val2,
    output logic [DATA_W-1:0] ex_reg2,
    output logic [DATA_W-1:0] ex_pc,
    output logic [REG_AW-1:0] ex_dest,
    output logic [REG_AW-1:0] ex_src1,
    output logic [REG_AW-1:0] ex_src2
);

    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_ADD  = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000011;
    localparam logic [5:0] OP_AND  = 6'b000101;
    localparam logic [5:0] OP_OR   = 6'b000110;
    localparam logic [5:0] OP_NOR  = 6'b000111;
    localparam logic [5:0] OP_XOR  = 6'b001000;
    localparam logic [5:0] OP_SLA  = 6'b001001;
    localparam logic [5:0] OP_SLL  = 6'b001010;
    localparam logic [5:0] OP_SRA  = 6'b001011;
    localparam logic [5:0] OP_SRL  = 6'b001100;
    localparam logic [5:0] OP_ADDI = 6'b100000;
    localparam logic [5:0] OP_SUBI = 6'b100001;
    localparam logic [5:0] OP_LD   = 6'b100100;
    localparam logic [5:0] OP_ST   = 6'b100101;
    localparam logic [5:0] OP_BEZ  = 6'b101000;
    localparam logic [5:0] OP_BNE  = 6'b101001;
    localparam logic [5:0] OP_JMP  = 6'b101010;

    typedef enum logic [3:0] {
        CMD_ADD = 4'b0000,
        CMD_SUB = 4'b0010,
        CMD_AND = 4'b0100,
        CMD_OR  = 4'b0101,
        CMD_NOR = 4'b0110,
        CMD_XOR = 4'b0111,
        CMD_SHL = 4'b1000,
        CMD_SRA = 4'b1001,
        CMD_SRL = 4'b1010
    } exe_cmd_e;

    // Instruction fields
    logic [5:0]        opcode;
    logic              is_imm;
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] imm_sext;

    assign opcode   = instr[31:26];
    assign is_imm   = opcode[5];
    assign src1     = instr[21 +: REG_AW];
    assign src2     = instr[16 +: REG_AW];
    assign dest     = is_imm ? instr[16 +: REG_AW] : instr[11 +: REG_AW];
    assign imm_sext = {{(DATA_W-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};

    // Control decode
    logic     d_wb_en;
    logic [1:0] d_mem;
    logic [1:0] d_br;
    exe_cmd_e d_cmd;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        d_wb_en = 1'b0;
        d_mem   = 2'b00;
        d_br    = 2'b00;
        d_cmd   = CMD_ADD;
        case (opcode)
            OP_ADD:  begin d_wb_en = 1'b1; d_cmd = CMD_ADD; end
            OP_SUB:  begin d_wb_en = 1'b1; d_cmd = CMD_SUB; end
            OP_AND:  begin d_wb_en = 1'b1; d_cmd = CMD_AND; end
            OP_OR:   begin d_wb_en = 1'b1; d_cmd = CMD_OR;  end
            OP_NOR:  begin d_wb_en = 1'b1; d_cmd = CMD_NOR; end
            OP_XOR:  begin d_wb_en = 1'b1; d_cmd = CMD_XOR; end
            OP_SLA,
            OP_SLL:  begin d_wb_en = 1'b1; d_cmd = CMD_SHL; end
            OP_SRA:  begin d_wb_en = 1'b1; d_cmd = CMD_SRA; end
            OP_SRL:  begin d_wb_en = 1'b1; d_cmd = CMD_SRL; end
            OP_ADDI: begin d_wb_en = 1'b1; d_cmd = CMD_ADD; end
            OP_SUBI: begin d_wb_en = 1'b1; d_cmd = CMD_SUB; end
            OP_LD:   begin d_wb_en = 1'b1; d_mem = 2'b10;   end
            OP_ST:   d_mem = 2'b01;
            OP_BEZ:  d_br  = 2'b01;
            OP_BNE:  d_br  = 2'b10;
            OP_JMP:  d_br  = 2'b11;
            default: d_wb_en = 1'b0;
        endcase
    end

    // Register file
    logic [DATA_W-1:0] rf [REG_CNT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the register file is reset because software relies on every register reading 0 after reset.
            for (int i = 0; i < REG_CNT; i++) rf[i] <= '0;
        end else if (wb_en && wb_dest != '0) begin
            rf[wb_dest] <= wb_data;
        end
    end

    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

`ifdef ID_BYPASS_EN
    assign rd1 = (src1 == '0) ? '0 : (wb_en && wb_dest == src1) ? wb_data : rf[src1];
    assign rd2 = (src2 == '0) ? '0 : (wb_en && wb_dest == src2) ? wb_data : rf[src2];
`else
    assign rd1 = (src1 == '0) ? '0 : rf[src1];
    assign rd2 = (src2 == '0) ? '0 : rf[src2];
`endif

    // Load-use detection against the load currently held in ID/EXE
    logic src1_used;
    logic src2_used;
    logic hazard;
    logic ex_hold;

    assign src1_used = (opcode != OP_JMP);
    assign src2_used = !is_imm || (opcode == OP_ST) || (opcode == OP_BNE);
    assign hazard    = ex_valid && ex_mem_sig[1] && (ex_dest != '0) &&
                       ((src1_used && ex_dest == src1) || (src2_used && ex_dest == src2));
    assign ex_hold   = ex_valid && !ex_ready;
    assign id_stall  = if_valid && (hazard || ex_hold);

    logic kill;
    logic load;

    assign kill = flush || (!ex_hold && hazard);
    assign load = !flush && !ex_hold && !hazard;

    // ID/EXE register: flush beats back-pressure, back-pressure beats bubble insertion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            ex_valid   <= 1'b0;
            ex_wb_en   <= 1'b0;
            ex_mem_sig <= 2'b00;
            ex_br_type <= 2'b00;
            ex_cmd     <= 4'b0000;
            ex_val1    <= '0;
            ex_val2    <= '0;
            ex_reg2    <= '0;
            ex_pc      <= '0;
            ex_dest    <= '0;
            ex_src1    <= '0;
            ex_src2    <= '0;
        end else if (kill) begin
            ex_valid   <= 1'b0;
            ex_wb_en   <= 1'b0;
            ex_mem_sig <= 2'b00;
            ex_br_type <= 2'b00;
            ex_cmd     <= 4'b0000;
            ex_val1    <= '0;
            ex_val2    <= '0;
            ex_reg2    <= '0;
            ex_pc      <= '0;
            ex_dest    <= '0;
            ex_src1    <= '0;
            ex_src2    <= '0;
        end else if (load) begin
            ex_valid   <= if_valid;
            ex_wb_en   <= if_valid & d_wb_en;
            ex_mem_sig <= if_valid ? d_mem : 2'b00;
            ex_br_type <= if_valid ? d_br : 2'b00;
            ex_cmd     <= if_valid ? d_cmd : CMD_ADD;
            ex_val1    <= rd1;
            ex_val2    <= is_imm ? imm_sext : rd2;
            ex_reg2    <= rd2;
            ex_pc      <= pc_in;
            ex_dest    <= dest;
            ex_src1    <= src1;
            ex_src2    <= src2;
        end
    end

endmodule

// File: tb/tb_id_stage_hz.sv
// Self-checking bench for id_stage_hz: decode table, hand-written hazard/stall/flush/bypass/reset
// sequences, and randomized traffic against a cycle-level behavioural model.
module tb_id_stage_hz;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [5:0] OP_ADD = 6'b000001, OP_SUB = 6'b000011, OP_AND = 6'b000101,
                           OP_OR  = 6'b000110, OP_NOR = 6'b000111, OP_XOR = 6'b001000,
                           OP_SLA = 6'b001001, OP_SLL = 6'b001010, OP_SRA = 6'b001011,
                           OP_SRL = 6'b001100, OP_ADDI = 6'b100000, OP_SUBI = 6'b100001,
                           OP_LD  = 6'b100100, OP_ST  = 6'b100101, OP_BEZ = 6'b101000,
                           OP_BNE = 6'b101001, OP_JMP = 6'b101010, OP_NOP = 6'b000000,
                           OP_BAD = 6'b111111;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              if_valid = 1'b0;
    logic [31:0]       instr = '0;
    logic [DATA_W-1:0] pc_in = '0;
    logic              id_stall;
    logic              ex_ready = 1'b0;
    logic              flush = 1'b0;
    logic              wb_en = 1'b0;
    logic [REG_AW-1:0] wb_dest = '0;
    logic [DATA_W-1:0] wb_data = '0;
    logic              ex_valid, ex_wb_en;
    logic [1:0]        ex_mem_sig, ex_br_type;
    logic [3:0]        ex_cmd;
    logic [DATA_W-1:0] ex_val1, ex_val2, ex_reg2, ex_pc;
    logic [REG_AW-1:0] ex_dest, ex_src1, ex_src2;
    logic [8:0]        ex_ctl;

    assign ex_ctl = {ex_wb_en, ex_mem_sig, ex_br_type, ex_cmd};

    id_stage_hz dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .instr(instr), .pc_in(pc_in),
        .id_stall(id_stall), .ex_ready(ex_ready), .flush(flush), .wb_en(wb_en),
        .wb_dest(wb_dest), .wb_data(wb_data), .ex_valid(ex_valid), .ex_wb_en(ex_wb_en),
        .ex_mem_sig(ex_mem_sig), .ex_br_type(ex_br_type), .ex_cmd(ex_cmd),
        .ex_val1(ex_val1), .ex_val2(ex_val2), .ex_reg2(ex_reg2), .ex_pc(ex_pc),
        .ex_dest(ex_dest), .ex_src1(ex_src1), .ex_src2(ex_src2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] s1,
                                          input logic [4:0] s2, input logic [4:0] d);
        return {op, s1, s2, d, 11'b0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s1,
                                          input logic [4:0] d, input logic [15:0] imm);
        return {op, s1, d, imm};
    endfunction

    function automatic logic [8:0] c9(input logic wb, input logic [1:0] mem,
                                      input logic [1:0] br, input logic [3:0] cmd);
        return {wb, mem, br, cmd};
    endfunction

    // Opcode-to-control table written straight from the opcode map
    typedef struct {
        logic [5:0] op;
        logic [8:0] ctl;
    } opmap_t;
    opmap_t opmap [17];

    function automatic logic [8:0] spec_ctl(input logic [5:0] op);
        for (int k = 0; k < 17; k++)
            if (opmap[k].op == op) return opmap[k].ctl;
        return 9'h0;
    endfunction

    // Behavioural model of the ID/EXE register and the architectural register file
    typedef struct {
        logic        v;
        logic [8:0]  ctl;
        logic [31:0] val1, val2, reg2, pc;
        logic [4:0]  dest, src1, src2;
    } ex_t;
    ex_t         m;
    logic [31:0] mrf [32];

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
`ifdef ID_BYPASS_EN
        if (wb_en && wb_dest == r) return wb_data;
`endif
        return mrf[r];
    endfunction

    function automatic logic m_hazard();
        logic [5:0] op;
        logic       s1_used, s2_used;
        op      = instr[31:26];
        s1_used = (op != OP_JMP);
        s2_used = !op[5] || op == OP_ST || op == OP_BNE;
        return m.v && m.ctl[7] && m.dest != 5'd0 &&
               ((s1_used && m.dest == instr[25:21]) || (s2_used && m.dest == instr[20:16]));
    endfunction

    function automatic logic m_stall();
        return if_valid && (m_hazard() || (m.v && !ex_ready));
    endfunction

    task automatic m_step();
        logic h;
        h = m_hazard();
        if (flush || (!(m.v && !ex_ready) && h)) begin
            m.v   = 1'b0;
            m.ctl = 9'h0;
        end else if (!(m.v && !ex_ready)) begin
            m.v    = if_valid;
            m.ctl  = if_valid ? spec_ctl(instr[31:26]) : 9'h0;
            m.val1 = m_read(instr[25:21]);
            m.reg2 = m_read(instr[20:16]);
            m.val2 = instr[31] ? {{16{instr[15]}}, instr[15:0]} : m.reg2;
            m.dest = instr[31] ? instr[20:16] : instr[15:11];
            m.src1 = instr[25:21];
            m.src2 = instr[20:16];
            m.pc   = pc_in;
        end
        if (wb_en && wb_dest != 5'd0) mrf[wb_dest] = wb_data;
    endtask

    task automatic m_compare(input int c);
        check($sformatf("r%0d_valid", c), ex_valid, m.v);
        check($sformatf("r%0d_ctl", c), ex_ctl, m.ctl);
        if (m.v) begin
            check($sformatf("r%0d_val1", c), ex_val1, m.val1);
            check($sformatf("r%0d_val2", c), ex_val2, m.val2);
            check($sformatf("r%0d_reg2", c), ex_reg2, m.reg2);
            check($sformatf("r%0d_dest", c), ex_dest, m.dest);
            check($sformatf("r%0d_src", c), {ex_src1, ex_src2}, {m.src1, m.src2});
            check($sformatf("r%0d_pc", c), ex_pc, m.pc);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [20];
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_XOR, OP_SLA, OP_SLL, OP_SRA, OP_SRL,
                OP_ADDI, OP_SUBI, OP_LD, OP_ST, OP_BEZ, OP_BNE, OP_JMP, OP_NOP, OP_BAD, 6'b010101};
        if ($urandom_range(0, 3) == 0)
            return {OP_LD, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
        return {ops[$urandom_range(0, 19)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                16'($urandom)};
    endfunction

    typedef struct {
        logic [31:0] ins;
        logic [8:0]  ctl;
        logic [31:0] val1, val2, reg2;
        logic [4:0]  dest;
    } vec_t;
    vec_t vec [19];

    initial begin
        opmap = '{'{OP_ADD, c9(1, 0, 0, 4'b0000)}, '{OP_SUB, c9(1, 0, 0, 4'b0010)},
                  '{OP_AND, c9(1, 0, 0, 4'b0100)}, '{OP_OR,  c9(1, 0, 0, 4'b0101)},
                  '{OP_NOR, c9(1, 0, 0, 4'b0110)}, '{OP_XOR, c9(1, 0, 0, 4'b0111)},
                  '{OP_SLA, c9(1, 0, 0, 4'b1000)}, '{OP_SLL, c9(1, 0, 0, 4'b1000)},
                  '{OP_SRA, c9(1, 0, 0, 4'b1001)}, '{OP_SRL, c9(1, 0, 0, 4'b1010)},
                  '{OP_ADDI, c9(1, 0, 0, 4'b0000)}, '{OP_SUBI, c9(1, 0, 0, 4'b0010)},
                  '{OP_LD,  c9(1, 2'b10, 0, 4'b0000)}, '{OP_ST, c9(0, 2'b01, 0, 4'b0000)},
                  '{OP_BEZ, c9(0, 0, 2'b01, 4'b0000)}, '{OP_BNE, c9(0, 0, 2'b10, 4'b0000)},
                  '{OP_JMP, c9(0, 0, 2'b11, 4'b0000)}};

        // Registers r1..r7 hold 0x100+i when the table runs
        vec[0]  = '{32'h8001FFFD,                c9(1, 0, 0, 4'b0000), 32'h0,   32'hFFFFFFFD, 32'h101, 5'd1};
        vec[1]  = '{enc_r(OP_ADD, 1, 2, 3),      c9(1, 0, 0, 4'b0000), 32'h101, 32'h102, 32'h102, 5'd3};
        vec[2]  = '{enc_r(OP_SUB, 1, 2, 3),      c9(1, 0, 0, 4'b0010), 32'h101, 32'h102, 32'h102, 5'd3};
        vec[3]  = '{enc_r(OP_AND, 4, 5, 6),      c9(1, 0, 0, 4'b0100), 32'h104, 32'h105, 32'h105, 5'd6};
        vec[4]  = '{enc_r(OP_OR, 5, 6, 7),       c9(1, 0, 0, 4'b0101), 32'h105, 32'h106, 32'h106, 5'd7};
        vec[5]  = '{enc_r(OP_NOR, 6, 7, 1),      c9(1, 0, 0, 4'b0110), 32'h106, 32'h107, 32'h107, 5'd1};
        vec[6]  = '{enc_r(OP_XOR, 7, 1, 2),      c9(1, 0, 0, 4'b0111), 32'h107, 32'h101, 32'h101, 5'd2};
        vec[7]  = '{enc_r(OP_SLA, 1, 3, 4),      c9(1, 0, 0, 4'b1000), 32'h101, 32'h103, 32'h103, 5'd4};
        vec[8]  = '{enc_r(OP_SLL, 2, 3, 5),      c9(1, 0, 0, 4'b1000), 32'h102, 32'h103, 32'h103, 5'd5};
        vec[9]  = '{enc_r(OP_SRA, 3, 4, 6),      c9(1, 0, 0, 4'b1001), 32'h103, 32'h104, 32'h104, 5'd6};
        vec[10] = '{enc_r(OP_SRL, 4, 0, 7),      c9(1, 0, 0, 4'b1010), 32'h104, 32'h0,   32'h0,   5'd7};
        vec[11] = '{enc_i(OP_SUBI, 2, 4, 16'h0005), c9(1, 0, 0, 4'b0010), 32'h102, 32'h5,   32'h104, 5'd4};
        vec[12] = '{enc_i(OP_LD, 1, 6, 16'h0008),   c9(1, 2'b10, 0, 4'b0000), 32'h101, 32'h8, 32'h106, 5'd6};
        vec[13] = '{enc_i(OP_ST, 1, 7, 16'h7FFC),   c9(0, 2'b01, 0, 4'b0000), 32'h101, 32'h7FFC, 32'h107, 5'd7};
        vec[14] = '{enc_i(OP_BEZ, 3, 0, 16'hFFF0),  c9(0, 0, 2'b01, 4'b0000), 32'h103, 32'hFFFFFFF0, 32'h0, 5'd0};
        vec[15] = '{enc_i(OP_BNE, 3, 4, 16'h0010),  c9(0, 0, 2'b10, 4'b0000), 32'h103, 32'h10, 32'h104, 5'd4};
        vec[16] = '{enc_i(OP_JMP, 0, 0, 16'h8000),  c9(0, 0, 2'b11, 4'b0000), 32'h0, 32'hFFFF8000, 32'h0, 5'd0};
        vec[17] = '{32'h0,                          c9(0, 0, 0, 4'b0000), 32'h0, 32'h0, 32'h0, 5'd0};
        vec[18] = '{enc_i(OP_BAD, 1, 2, 16'h1234),  c9(0, 0, 0, 4'b0000), 32'h101, 32'h1234, 32'h102, 5'd2};

        // Reset state, with a valid instruction and back-pressure present
        if_valid = 1'b1;
        instr    = enc_i(OP_LD, 1, 2, 0);
        #12;
        check("rst_valid", ex_valid, 0);
        check("rst_ctl", ex_ctl, 0);
        check("rst_ops", ex_val1 | ex_val2 | ex_reg2 | ex_pc, 0);
        check("rst_idx", {ex_dest, ex_src1, ex_src2}, 0);
        check("rst_stall", id_stall, 0);
        if_valid = 1'b0;
        ex_ready = 1'b1;
        rst      = 1'b1;
        tick();
        check("post_rst_valid", ex_valid, 0);

        for (int i = 1; i < 8; i++) begin
            wb_en   = 1'b1;
            wb_dest = 5'(i);
            wb_data = 32'h100 + 32'(i);
            tick();
        end
        wb_en = 1'b0;

        // Decode table, each vector separated by an idle slot
        for (int i = 0; i < 19; i++) begin
            logic [31:0] t;
            t        = vec[i].ins;
            instr    = t;
            pc_in    = 32'h1000 + 32'(4 * i);
            if_valid = 1'b1;
            tick();
            check($sformatf("v%0d_valid", i), ex_valid, 1);
            check($sformatf("v%0d_ctl", i), ex_ctl, vec[i].ctl);
            check($sformatf("v%0d_val1", i), ex_val1, vec[i].val1);
            check($sformatf("v%0d_val2", i), ex_val2, vec[i].val2);
            check($sformatf("v%0d_reg2", i), ex_reg2, vec[i].reg2);
            check($sformatf("v%0d_dest", i), ex_dest, vec[i].dest);
            check($sformatf("v%0d_src", i), {ex_src1, ex_src2}, {t[25:21], t[20:16]});
            check($sformatf("v%0d_pc", i), ex_pc, 32'h1000 + 32'(4 * i));
            if_valid = 1'b0;
            tick();
        end

        // Load-use: LD r2 then ADD r3,r2,r4 costs one bubble
        if_valid = 1'b1;
        instr    = enc_i(OP_LD, 1, 2, 0);
        @(negedge clk);
        check("lu_nostall", id_stall, 0);
        tick();
        check("lu_ld_mem", ex_mem_sig, 2'b10);
        instr = enc_r(OP_ADD, 2, 4, 3);
        @(negedge clk);
        check("lu_stall", id_stall, 1);
        tick();
        check("lu_bubble_valid", ex_valid, 0);
        check("lu_bubble_ctl", ex_ctl, 0);
        @(negedge clk);
        check("lu_stall_once", id_stall, 0);
        tick();
        check("lu_add_valid", ex_valid, 1);
        check("lu_add_src1", ex_src1, 2);
        check("lu_add_val1", ex_val1, 32'h102);
        check("lu_add_ctl", ex_ctl, c9(1, 0, 0, 4'b0000));
        if_valid = 1'b0;
        tick();

        // Back-pressure holds SUB for three cycles
        if_valid = 1'b1;
        instr    = enc_r(OP_SUB, 1, 2, 3);
        tick();
        instr    = enc_r(OP_OR, 5, 6, 7);
        ex_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("bp%0d_stall", k), id_stall, 1);
            tick();
            check($sformatf("bp%0d_valid", k), ex_valid, 1);
            check($sformatf("bp%0d_ctl", k), ex_ctl, c9(1, 0, 0, 4'b0010));
            check($sformatf("bp%0d_hold", k), {ex_dest, ex_val1[15:0]}, {5'd3, 16'h0101});
        end
        ex_ready = 1'b1;
        @(negedge clk);
        check("bp_release_stall", id_stall, 0);
        tick();
        check("bp_next_ctl", ex_ctl, c9(1, 0, 0, 4'b0101));
        check("bp_next_dest", ex_dest, 7);

        // Flush wins over back-pressure
        ex_ready = 1'b0;
        flush    = 1'b1;
        instr    = enc_r(OP_ADD, 1, 2, 3);
        tick();
        check("fl_valid", ex_valid, 0);
        check("fl_ctl", ex_ctl, 0);
        flush    = 1'b0;
        ex_ready = 1'b1;
        if_valid = 1'b0;
        tick();

        // WB write and read of r5 in the same cycle; writes to r0 are dropped
        if_valid = 1'b1;
        instr    = enc_r(OP_ADD, 5, 0, 6);
        wb_en    = 1'b1;
        wb_dest  = 5'd5;
        wb_data  = 32'hDEAD;
        tick();
`ifdef ID_BYPASS_EN
        check("wb_same_cycle", ex_val1, 32'hDEAD);
`else
        check("wb_same_cycle", ex_val1, 32'h105);
`endif
        wb_en = 1'b0;
        tick();
        check("wb_next_cycle", ex_val1, 32'hDEAD);
        instr   = enc_r(OP_ADD, 0, 0, 6);
        wb_en   = 1'b1;
        wb_dest = 5'd0;
        wb_data = 32'hBEEF;
        tick();
        check("wb_r0_same", ex_val1, 0);
        wb_en = 1'b0;
        tick();
        check("wb_r0_after", ex_val1, 0);

        // Reset asserted in the middle of a load-use stall
        instr = enc_i(OP_LD, 1, 2, 0);
        tick();
        instr = enc_r(OP_ADD, 2, 4, 3);
        @(negedge clk);
        check("rh_stall", id_stall, 1);
        #2;
        rst = 1'b0;
        #1;
        check("rh_valid", ex_valid, 0);
        check("rh_ctl", ex_ctl, 0);
        check("rh_ops", ex_val1 | ex_val2 | ex_reg2 | ex_pc, 0);
        check("rh_stall_off", id_stall, 0);
        if_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        m   = '{default: '0};
        for (int r = 0; r < 32; r++) mrf[r] = 32'h0;

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            if_valid = ($urandom_range(0, 3) != 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 9) == 0);
            wb_en    = 1'($urandom_range(0, 1));
            wb_dest  = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            pc_in    = $urandom;
            instr    = rand_instr();
            @(negedge clk);
            check($sformatf("r%0d_stall", c), id_stall, m_stall());
            @(posedge clk);
            m_step();
            #1;
            m_compare(c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
